// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the data-memory store path.
// Holds the store widths, the FSM encoding and the store legality check.
package riscv_mem_pkg;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = WORD_W / BYTE_W;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Legal width code and natural alignment for that width.
  function automatic logic store_legal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   return 1'b1;
      F3_SH:   return !a[0];
      F3_SW:   return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// MEM-stage request side and word-memory side of the store unit.
// slave = the store unit, master = the pipeline/memory driving it.
interface store_rmw_if;
  import riscv_mem_pkg::*;

  logic              LOAD;
  logic              STORE;
  logic [2:0]        FUNCT3;
  logic [WORD_W-1:0] ADDRESS;
  logic [WORD_W-1:0] DATA_IN;
  logic              BUSYWAIT;
  logic              MISALIGNED;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [WORD_W-1:0] MEM_ADDRESS;
  logic [WORD_W-1:0] MEM_WRITEDATA;
  logic [WORD_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  LOAD, STORE, FUNCT3, ADDRESS, DATA_IN, MEM_READDATA, MEM_BUSYWAIT,
    output BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output LOAD, STORE, FUNCT3, ADDRESS, DATA_IN, MEM_READDATA, MEM_BUSYWAIT,
    input  BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/store_merge.sv
// Combinational byte-lane merge of store data into an old memory word.
// Each lane either keeps the old byte or takes the replicated store data.
module store_merge
  import riscv_mem_pkg::*;
(
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  output logic [WORD_W-1:0] new_word_o
);

  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][BYTE_W-1:0] old_l, rep_l, new_l;

  assign old_l = old_word_i;

  // Replicate the store data so lane l always finds its byte at rep_l[l].
  always_comb begin
    be    = '0;
    rep_l = data_i;
    case (funct3_i)
      F3_SB: begin
        be[addr_lo_i] = 1'b1;
        rep_l         = {NUM_LANES{data_i[BYTE_W-1:0]}};
      end
      F3_SH: begin
        be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        rep_l = {2{data_i[2*BYTE_W-1:0]}};
      end
      F3_SW:   be = '1;
      default: be = '0;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign new_l[l] = be[l] ? rep_l[l] : old_l[l];
  end

  assign new_word_o = new_l;

endmodule

// File: rtl/store_rmw_unit.sv
// SB/SH/SW store unit for a word-only data memory; sub-word stores do a
// read-modify-write and BUSYWAIT holds the pipeline until the write lands.
module store_rmw_unit
  import riscv_mem_pkg::*;
#(
  parameter bit SKIP_READ_ON_SW = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  store_rmw_if.slave bus
);

  state_e            state_q;
  logic [WORD_W-1:0] addr_q, data_q, wdata_q, wdata_d;
  logic [2:0]        f3_q;
  logic              req, legal, req_ok, skip_rd;

  assign req     = bus.STORE && !bus.LOAD && (state_q == IDLE);
  assign legal   = store_legal(bus.FUNCT3, bus.ADDRESS[1:0]);
  assign req_ok  = req && legal;
  assign skip_rd = SKIP_READ_ON_SW && (bus.FUNCT3 == F3_SW);

  store_merge u_merge (
    .old_word_i (bus.MEM_READDATA),
    .data_i     (data_q),
    .funct3_i   (f3_q),
    .addr_lo_i  (addr_q[1:0]),
    .new_word_o (wdata_d)
  );

  // wdata_q is preloaded with DATA_IN so a skipped-read SW writes it directly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      f3_q    <= F3_SB;
    end else begin
      case (state_q)
        IDLE: if (req_ok) begin
          addr_q  <= bus.ADDRESS;
          data_q  <= bus.DATA_IN;
          f3_q    <= bus.FUNCT3;
          wdata_q <= bus.DATA_IN;
          state_q <= skip_rd ? WRITE : READ;
        end
        READ: if (!bus.MEM_BUSYWAIT) begin
          wdata_q <= wdata_d;
          state_q <= WRITE;
        end
        WRITE:   if (!bus.MEM_BUSYWAIT) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset is synchronous, so outputs are gated to read as cleared in the reset cycle itself.
  assign bus.BUSYWAIT      = !RESET && (req_ok || state_q == READ || state_q == WRITE);
  assign bus.MISALIGNED    = !RESET && req && !legal;
  assign bus.MEM_READ      = !RESET && (state_q == READ);
  assign bus.MEM_WRITE     = !RESET && (state_q == WRITE);
  assign bus.MEM_ADDRESS   = RESET ? '0 : {addr_q[WORD_W-1:2], 2'b00};
  assign bus.MEM_WRITEDATA = RESET ? '0 : wdata_q;

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-side counterpart of the data memory load refiner: it takes SB/SH/SW requests from the MEM stage and writes them into the word-only data memory. Byte and halfword stores use a read-modify-write. It sits between the MEM pipeline stage and the data memory. It drives BUSYWAIT to stall the pipeline until the write completes.

## Interface
- SKIP_READ_ON_SW, default 1: when set, SW goes straight to the write with no read phase.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOAD  in  1  load request from MEM stage. Used only to detect the illegal LOAD && STORE case.
- STORE  in  1  store request from MEM stage.
- FUNCT3  in  3  store width: 000 SB, 001 SH, 010 SW.
- ADDRESS  in  32  byte address from the ALU.
- DATA_IN  in  32  store data from the register file.
- BUSYWAIT  out  1  pipeline stall request.
- MISALIGNED  out  1  illegal store flag.
- MEM_READ  out  1  data memory read strobe.
- MEM_WRITE  out  1  data memory write strobe.
- MEM_ADDRESS  out  32  word-aligned address: {addr[31:2],2'b00}.
- MEM_WRITEDATA  out  32  merged word to write.
- MEM_READDATA  in  32  word read from memory.
- MEM_BUSYWAIT  in  1  memory not ready; high holds the current phase.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Valid request: STORE && !LOAD in IDLE, with a legal FUNCT3 and correct alignment.
- IDLE behaviour:
  - On a valid request, latch ADDRESS, FUNCT3 and DATA_IN.
  - Next state is WRITE for SW when SKIP_READ_ON_SW=1; otherwise READ.
- Illegal request, evaluated in IDLE while STORE && !LOAD:
  - Illegal cases: FUNCT3 not in {000,001,010}, SH with addr[0]=1, or SW with addr[1:0]≠00.
  - MISALIGNED=1 combinationally; no memory access; BUSYWAIT=0; state stays IDLE.
- LOAD && STORE both high: ignored, no access, MISALIGNED=0.
- READ: MEM_READ=1. While MEM_BUSYWAIT=1, remain in READ. At the first edge with MEM_BUSYWAIT=0, capture the merged word and go to WRITE.
- Merge rules (k = latched addr[1:0]):
  - SB: lane k (bits 8k+7:8k) takes DATA_IN[7:0]; the other lanes keep MEM_READDATA.
  - SH: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], using DATA_IN[15:0].
  - SW: the whole word is DATA_IN.
- WRITE: MEM_WRITE=1 with MEM_WRITEDATA = merged word. Remain in WRITE while MEM_BUSYWAIT=1; otherwise go to DONE.
- DONE: BUSYWAIT=0, which lets the pipeline advance on this edge. STORE is ignored in DONE because it still belongs to the same instruction. Next state is IDLE.
- Outputs MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA are decoded from the state and latched registers only (Moore).
- MEM_READ and MEM_WRITE are never both high.

## Timing
- Reset (synchronous) sets state to IDLE and clears all latched registers.
- While RESET is high: BUSYWAIT=0, MISALIGNED=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
- BUSYWAIT = (state==IDLE && valid request) || state==READ || state==WRITE. It rises combinationally in the cycle STORE arrives.
- Stall cycles with zero-wait memory:
  - SB/SH: 3 (IDLE, READ, WRITE), with BUSYWAIT low in the 4th cycle (DONE).
  - SW with SKIP_READ_ON_SW=1: 2.
  - SW with SKIP_READ_ON_SW=0: 3.
- Each MEM_BUSYWAIT-high cycle adds exactly one stall cycle to the current phase.
- Reset mid-operation: the state is IDLE after the edge at which RESET is sampled high. Any pending write is abandoned and MEM_WRITE is low from that cycle on.
- Inputs ADDRESS, FUNCT3 and DATA_IN are don't-care after the IDLE capture edge.

## Structure
- Package riscv_mem_pkg holds:
  - FUNCT3 constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010;
  - the state encoding IDLE/READ/WRITE/DONE;
  - the word and byte width constants.
- Sub-module store_merge is purely combinational: (old_word, data, funct3, addr[1:0]) → new_word.
  - Instantiated once in this block.
  - Reusable by the verification model.

## Test plan
- SB, ADDRESS=0x102, DATA_IN=0xAB, memory word 0x11223344, zero-wait: MEM_READ in cycle 1, MEM_WRITE cycle 2 with 0x11AB3344 at 0x100, BUSYWAIT 1,1,1,0.
- SH, ADDRESS=0x206, DATA_IN=0xBEEF, word 0xCAFEF00D, MEM_BUSYWAIT high 2 cycles in READ and 1 in WRITE: write 0xBEEFF00D at 0x204, total 6 stall cycles.
- SW, ADDRESS=0x300, DATA_IN=0xDEADBEEF, SKIP_READ_ON_SW=1: no MEM_READ, MEM_WRITE in cycle 1, BUSYWAIT 1,1,0.
- Misaligned SW at 0x301 and SH at 0x401, plus FUNCT3=011: MISALIGNED=1, BUSYWAIT=0, no MEM_READ or MEM_WRITE.
- RESET asserted during the WRITE phase with MEM_BUSYWAIT=1: next cycle state IDLE, MEM_WRITE=0, BUSYWAIT=0. A subsequent SB completes normally.
- LOAD=STORE=1: no memory activity. A back-to-back SB issued right after DONE starts a fresh transaction.
